ttt_turn_sched: RTL
===================

// Module: ttt_turn_sched
// PURPOSE
// Turn scheduler/controller for the tic-tac-toe board datapath. Arbitrates board
// writes between two players and owns the move cursor. Enforces a per-turn
// timeout with auto-move, and detects win/draw. Drives the board through a
// single write port and reads back the board state.
// PARAMETERS
// TIMEOUT_CYC   50   WAIT cycles per turn before auto-commit at cursor (>=2)
// CNT_W         6    timer width; must hold TIMEOUT_CYC-1
// FIRST_PLAYER  0    player owning the first turn (0=P1, 1=P2)
// PORTS
// clk        in   1      system clock, rising edge
// rst        in   1      asynchronous, active-high reset
// next_p1    in   1      P1 cursor-advance button (level)
// sel_p1     in   1      P1 commit button (level)
// next_p2    in   1      P2 cursor-advance button (level)
// sel_p2     in   1      P2 commit button (level)
// board_i    in   18     cell k at [2k+1:2k]: 00 empty, 01 P1, 10 P2, 11 occupied
// wr_en      out  1      one-cycle board write strobe
// wr_idx     out  4      cell index 0..8 for write
// wr_val     out  2      01 (P1) or 10 (P2)
// cursor     out  4      current cursor cell 0..8
// turn       out  1      player to move (0=P1, 1=P2)
// timer      out  CNT_W  remaining WAIT cycles
// winner     out  2      00 none, 01 P1, 10 P2, 11 draw
// game_over  out  1      winner != 00
// BEHAVIOUR
// - Reset values: state IDLE, turn=FIRST_PLAYER, cursor=0, timer=0, wr_en=0,
//   wr_idx=0, wr_val=0, winner=00, game_over=0, edge regs=0. All outputs registered.
// - Buttons are rising-edge detected (prev regs updated every cycle). Edges are
//   acted on only in WAIT, and only from the player given by turn; the other
//   player's buttons are ignored.
// - FSM: IDLE->SEEK (1 cycle after reset release).
//   SEEK: cursor=lowest-index empty cell; timer=TIMEOUT_CYC-1; ->WAIT.
//   WAIT: sel edge or timer==0 -> commit; otherwise next edge advances cursor and
//   timer decrements. Commit is ignored if board_i[cursor]!=00; in that case ->SEEK.
//   WRITE: wr_en=1, wr_idx=cursor, wr_val=turn?10:01; ->CHECK.
//   CHECK: evaluate board_i (already updated by the write). Win or draw ->DONE,
//   else toggle turn ->SEEK. DONE: hold winner/game_over until rst; all buttons ignored.
// - Next: cursor moves to the next empty index, cyclic 8->0, skipping occupied
//   cells. Only one empty cell -> cursor unchanged.
// - sel and next edges in the same cycle: sel wins, next dropped.
// - sel edge with timer==0: single commit.
// - Latency: sel edge sampled in WAIT cycle N -> wr_en high in N+1 -> CHECK N+2
//   -> next player's SEEK N+3, WAIT N+4.
// - Timeout: TIMEOUT_CYC WAIT cycles with no sel -> auto-commit at cursor.
// - Win: any of 8 lines (rows, columns, diagonals) with three equal 01 or 10
//   cells. Draw=11: no empty cells and no win.
// - Async rst mid-operation: immediate return to reset values; an in-flight
//   wr_en drops. A button held through reset creates no edge.
// STRUCTURE
// - ttt_pkg: cell_t enum (EMPTY, P1, P2), winner codes, state_t enum
//   (IDLE, SEEK, WAIT, WRITE, CHECK, DONE), WIN_LINES[8][3] index constant.
// - Sub-module ttt_win_eval: combinational board_i -> winner code; instantiated
//   once in CHECK datapath.
// - Next-empty search is a function in this module.
// TESTING
// 1. Reset with TIMEOUT_CYC=8, then P1 sel edge -> wr_en 1 cycle, wr_idx=0,
//    wr_val=01; turn=1; P2 WAIT with cursor=1.
// 2. P2 next,next,sel (board 0 occupied) -> cursor 1->2->3, write idx3 val 10.
//    P1 edges in P2 turn -> no wr_en.
// 3. No inputs for 8 WAIT cycles -> auto write at cursor; timer counts 7..0.
// 4. Moves P1:0, P2:3, P1:1, P2:4, P1:2 -> winner=01, game_over=1; later sel
//    -> no wr_en.
// 5. Moves 0,1,2,4,3,5,7,6,8 (alternating, P1 first) -> winner=11 after the 9th
//    CHECK.
// 6. rst pulse mid-WAIT with next_p1 held high -> outputs at reset values
//    immediately; no cursor move after release until next_p1 toggles.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared types and constants for the tic-tac-toe turn scheduler.
// Cell encoding, winner codes, FSM states and the eight win lines.
package ttt_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    P1    = 2'b01,
    P2    = 2'b10
  } cell_t;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_P1   = 2'b01;
  localparam logic [1:0] WIN_P2   = 2'b10;
  localparam logic [1:0] WIN_DRAW = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    SEEK,
    WAIT,
    WRITE,
    CHECK,
    DONE
  } state_t;

  localparam int WIN_LINES [8][3] = '{
    '{0, 1, 2},
    '{3, 4, 5},
    '{6, 7, 8},
    '{0, 3, 6},
    '{1, 4, 7},
    '{2, 5, 8},
    '{0, 4, 8},
    '{2, 4, 6}
  };

  function automatic logic [1:0] cell_at(
    input logic [17:0] b,
    input int          k
  );
    return b[2*k +: 2];
  endfunction

endpackage

// File: rtl/ttt_win_eval.sv
// Combinational board evaluator: returns the winner code for a board.
// A line wins only with three equal P1 or P2 cells; full board with no win is a draw.
module ttt_win_eval
  import ttt_pkg::*;
(
  input  logic [17:0] i_board,
  output logic [1:0]  o_winner
);

  logic       w_full;
  logic [1:0] w_win;
  logic [1:0] w_a;
  logic [1:0] w_b;
  logic [1:0] w_c;

  always_comb begin
    w_full = 1'b1;
    w_win  = WIN_NONE;
    w_a    = 2'b00;
    w_b    = 2'b00;
    w_c    = 2'b00;
    for (int k = 0; k < 9; k++) begin
      if (cell_at(i_board, k) == EMPTY)
        w_full = 1'b0;
    end
    for (int l = 0; l < 8; l++) begin
      w_a = cell_at(i_board, WIN_LINES[l][0]);
      w_b = cell_at(i_board, WIN_LINES[l][1]);
      w_c = cell_at(i_board, WIN_LINES[l][2]);
      if ((w_a == w_b) && (w_b == w_c) &&
          ((w_a == P1) || (w_a == P2)))
        w_win = w_a;
    end
    if ((w_win == WIN_NONE) && w_full)
      w_win = WIN_DRAW;
  end

  assign o_winner = w_win;

endmodule

// File: rtl/ttt_turn_sched.sv
// Turn scheduler: arbitrates board writes between two players,
// owns the cursor, enforces per-turn timeout and detects win/draw.
module ttt_turn_sched
  import ttt_pkg::*;
#(
  parameter int TIMEOUT_CYC  = 50,
  parameter int CNT_W        = 6,
  parameter int FIRST_PLAYER = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             next_p1,
  input  logic             sel_p1,
  input  logic             next_p2,
  input  logic             sel_p2,
  input  logic [17:0]      board_i,
  output logic             wr_en,
  output logic [3:0]       wr_idx,
  output logic [1:0]       wr_val,
  output logic [3:0]       cursor,
  output logic             turn,
  output logic [CNT_W-1:0] timer,
  output logic [1:0]       winner,
  output logic             game_over
);

  localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT_CYC - 1);

  function automatic logic [3:0] first_empty(
    input logic [17:0] b
  );
    logic [3:0] r;
    logic       hit;
    r   = 4'd0;
    hit = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (!hit && cell_at(b, k) == EMPTY) begin
        r   = 4'(k);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  // Cyclic scan after cur; cur itself is kept if no other cell is empty.
  function automatic logic [3:0] next_empty(
    input logic [17:0] b,
    input logic [3:0]  cur
  );
    logic [3:0] r;
    logic       hit;
    int         k;
    r   = cur;
    hit = 1'b0;
    for (int s = 1; s < 9; s++) begin
      k = (int'(cur) + s) % 9;
      if (!hit && cell_at(b, k) == EMPTY) begin
        r   = 4'(k);
        hit = 1'b1;
      end
    end
    return r;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_prev;
  logic [3:0]       r_cursor;
  logic             r_turn;
  logic [CNT_W-1:0] r_timer;
  logic             r_wr_en;
  logic [3:0]       r_wr_idx;
  logic [1:0]       r_wr_val;
  logic [1:0]       r_winner;
  logic             r_game_over;

  logic [3:0] w_btn;
  logic [3:0] w_edge;
  logic       w_next;
  logic       w_sel;
  logic       w_commit;
  logic       w_cur_free;
  logic [1:0] w_win;

  assign w_btn      = {sel_p2, next_p2, sel_p1, next_p1};
  assign w_edge     = w_btn & ~r_prev;
  assign w_next     = r_turn ? w_edge[2] : w_edge[0];
  assign w_sel      = r_turn ? w_edge[3] : w_edge[1];
  assign w_commit   = w_sel || (r_timer == '0);
  assign w_cur_free =
    (cell_at(board_i, int'(r_cursor)) == EMPTY);

  ttt_win_eval u_win (
    .i_board  (board_i),
    .o_winner (w_win)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:  w_state_nxt = SEEK;
      SEEK:  w_state_nxt = WAIT;
      WAIT: begin
        if (w_commit)
          w_state_nxt = w_cur_free ? WRITE : SEEK;
      end
      WRITE: w_state_nxt = CHECK;
      CHECK: begin
        if (w_win != WIN_NONE)
          w_state_nxt = DONE;
        else
          w_state_nxt = SEEK;
      end
      DONE:  w_state_nxt = DONE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev      <= '0;
      r_cursor    <= '0;
      r_turn      <= 1'(FIRST_PLAYER);
      r_timer     <= '0;
      r_wr_en     <= 1'b0;
      r_wr_idx    <= '0;
      r_wr_val    <= '0;
      r_winner    <= WIN_NONE;
      r_game_over <= 1'b0;
    end else begin
      r_prev  <= w_btn;
      r_wr_en <= 1'b0;
      unique case (r_state)
        SEEK: begin
          r_cursor <= first_empty(board_i);
          r_timer  <= TMAX;
        end
        WAIT: begin
          if (w_commit) begin
            if (w_cur_free) begin
              r_wr_en  <= 1'b1;
              r_wr_idx <= r_cursor;
              r_wr_val <= r_turn ? P2 : P1;
            end
          end else begin
            r_timer <= r_timer - CNT_W'(1);
            if (w_next)
              r_cursor <= next_empty(board_i, r_cursor);
          end
        end
        CHECK: begin
          if (w_win != WIN_NONE) begin
            r_winner    <= w_win;
            r_game_over <= 1'b1;
          end else begin
            r_turn <= ~r_turn;
          end
        end
        default: ;
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_idx    = r_wr_idx;
  assign wr_val    = r_wr_val;
  assign cursor    = r_cursor;
  assign turn      = r_turn;
  assign timer     = r_timer;
  assign winner    = r_winner;
  assign game_over = r_game_over;

endmodule
